// File: rtl/vga_pkg.sv
// Shared definitions for the VGA DAC output path:
// Bayer 2x2 thresholds, dither-depth check, sync polarity defaults.
package vga_pkg;

  localparam logic HS_POL_DEF = 1'b0;
  localparam logic VS_POL_DEF = 1'b0;

  function automatic logic [1:0] bayer(
    input logic row,
    input logic col
  );
    logic [1:0] b;
    unique case ({row, col})
      2'b00:   b = 2'd0;
      2'b01:   b = 2'd2;
      2'b10:   b = 2'd3;
      default: b = 2'd1;
    endcase
    return b;
  endfunction

  // Scale a 2-bit Bayer index down to the number of dropped bits.
  function automatic logic [1:0] bias_of(
    input logic [1:0] b,
    input int         d
  );
    logic [3:0] t;
    t = {2'b00, b} << d;
    return t[3:2];
  endfunction

  function automatic bit d_ok(input int d);
    return (d == 1) || (d == 2);
  endfunction

endpackage

// File: rtl/sync_edge_track.sv
// Per-sync history: two-stage delay matching the colour pipe,
// plus a leading-edge pulse from the first history stage.
module sync_edge_track #(
  parameter logic POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic s_i,
  output logic edge_o,
  output logic dly_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= ~POL;
      s2_q <= ~POL;
    end else begin
      s1_q <= s_i;
      s2_q <= s1_q;
    end
  end

  assign edge_o = (s_i == POL) && (s1_q != POL);
  assign dly_o  = s2_q;

endmodule

// File: rtl/vga_dither_out.sv
// 6-bit to 5-bit VGA output stage with 2x2 ordered dithering
// and optional per-frame temporal phase flip; 2-cycle latency.
module vga_dither_out
  import vga_pkg::*;
#(
  parameter int   IN_W     = 6,
  parameter int   OUT_W    = 5,
  parameter logic HS_POL   = HS_POL_DEF,
  parameter logic VS_POL   = VS_POL_DEF,
  parameter int   TEMPORAL = 1
) (
  input  logic             clk_vga,
  input  logic             reset,
  input  logic             dither_en,
  input  logic [IN_W-1:0]  r_i,
  input  logic [IN_W-1:0]  g_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [OUT_W-1:0] r_o,
  output logic [OUT_W-1:0] g_o,
  output logic [OUT_W-1:0] b_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_o
);

  localparam int D = IN_W - OUT_W;

  if (!d_ok(D)) begin : g_bad_d
    $error("vga_dither_out: IN_W-OUT_W must be 1 or 2");
  end

  logic hs_edge;
  logic vs_edge;

  sync_edge_track #(.POL(HS_POL)) u_hs (
    .clk_i  (clk_vga),
    .rst_i  (reset),
    .s_i    (hs_i),
    .edge_o (hs_edge),
    .dly_o  (hs_o)
  );

  sync_edge_track #(.POL(VS_POL)) u_vs (
    .clk_i  (clk_vga),
    .rst_i  (reset),
    .s_i    (vs_i),
    .edge_o (vs_edge),
    .dly_o  (vs_o)
  );

  logic       x_par_q, x_par_d;
  logic       y_par_q, y_par_d;
  logic       frame_q, frame_d;
  logic       en_q, en_d;
  logic       col;
  logic [1:0] bias;
  logic [1:0] bias_q;

  always_comb begin
    x_par_d = hs_edge ? 1'b0 : ~x_par_q;
    y_par_d = y_par_q;
    if (vs_edge) begin
      y_par_d = 1'b0;
    end else if (hs_edge) begin
      y_par_d = ~y_par_q;
    end
    frame_d = frame_q ^ vs_edge;
    en_d    = vs_edge ? dither_en : en_q;
  end

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      x_par_q <= 1'b0;
      y_par_q <= 1'b0;
      frame_q <= 1'b0;
      en_q    <= 1'b0;
      bias_q  <= 2'd0;
    end else begin
      x_par_q <= x_par_d;
      y_par_q <= y_par_d;
      frame_q <= frame_d;
      en_q    <= en_d;
      bias_q  <= bias;
    end
  end

  assign col  = x_par_q ^ ((TEMPORAL != 0) && frame_q);
  assign bias = en_q ? bias_of(bayer(y_par_q, col), D) : 2'd0;

  assign frame_o = frame_q;

  logic [IN_W-1:0]  cin  [3];
  logic [OUT_W-1:0] cout [3];

  assign cin[0] = r_i;
  assign cin[1] = g_i;
  assign cin[2] = b_i;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [IN_W-1:0]  in_q;
    logic [IN_W:0]    sum;
    logic [OUT_W:0]   shf;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;

    // Sum fits IN_W+1 bits; after >>D the top bit flags overflow.
    assign sum   = {1'b0, in_q} + (IN_W+1)'(bias_q);
    assign shf   = (OUT_W+1)'(sum >> D);
    assign out_d = shf[OUT_W] ? '1 : shf[OUT_W-1:0];

    always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
        in_q  <= '0;
        out_q <= '0;
      end else begin
        in_q  <= cin[c];
        out_q <= out_d;
      end
    end

    assign cout[c] = out_q;
  end

  assign r_o = cout[0];
  assign g_o = cout[1];
  assign b_o = cout[2];

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: default 6->5 build with temporal
// dither plus a 7->5 build without temporal dither.
module tb_vga_dither_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       dither_en;
  logic [5:0] r_i, g_i, b_i;
  logic       hs_i, vs_i;
  logic [4:0] r_o, g_o, b_o;
  logic       hs_o, vs_o, frame_o;
  logic [6:0] r2_i;
  logic [4:0] r2_o, g2_o, b2_o;
  logic       hs2_o, vs2_o, frame2_o;

  vga_dither_out dut (
    .clk_vga   (clk),
    .reset     (reset),
    .dither_en (dither_en),
    .r_i       (r_i),
    .g_i       (g_i),
    .b_i       (b_i),
    .hs_i      (hs_i),
    .vs_i      (vs_i),
    .r_o       (r_o),
    .g_o       (g_o),
    .b_o       (b_o),
    .hs_o      (hs_o),
    .vs_o      (vs_o),
    .frame_o   (frame_o)
  );

  vga_dither_out #(
    .IN_W     (7),
    .OUT_W    (5),
    .TEMPORAL (0)
  ) dut2 (
    .clk_vga   (clk),
    .reset     (reset),
    .dither_en (dither_en),
    .r_i       (r2_i),
    .g_i       (r2_i),
    .b_i       (r2_i),
    .hs_i      (hs_i),
    .vs_i      (vs_i),
    .r_o       (r2_o),
    .g_o       (g2_o),
    .b_o       (b2_o),
    .hs_o      (hs2_o),
    .vs_o      (vs2_o),
    .frame_o   (frame2_o)
  );

  typedef struct {
    logic [4:0] r, g, b;
    logic       hs, vs;
    logic [4:0] r2;
  } exp_t;

  typedef struct {
    logic [5:0] r;
    logic [6:0] r2;
    logic [4:0] er;
    logic [4:0] er2;
  } vec_t;

  exp_t q[$];
  vec_t tab[8];
  int   bay[4] = '{0, 2, 3, 1};

  int ntest = 0;
  int nfail = 0;
  int m_x, m_y, m_frame, m_en;
  logic m_hsp, m_vsp;
  logic [5:0] r_val;
  logic [6:0] r2_val;
  logic       en_val;
  bit         use_tab;
  logic [4:0] tab_r, tab_r2;
  int   hs_run, hs_run_last, flips;
  logic last_frame;

  function automatic int sat31(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    ntest++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_x = 0; m_y = 0; m_frame = 0; m_en = 0;
    m_hsp = 1'b1; m_vsp = 1'b1;
    hs_run = 0; last_frame = 1'b0;
  endtask

  task automatic chk_reset(input string name);
    ntest++;
    if (r_o !== 5'd0 || g_o !== 5'd0 || b_o !== 5'd0 ||
        hs_o !== 1'b1 || vs_o !== 1'b1 || frame_o !== 1'b0 ||
        r2_o !== 5'd0 || hs2_o !== 1'b1 || vs2_o !== 1'b1) begin
      nfail++;
      $display("FAIL %s got r=%0d g=%0d b=%0d hs=%b vs=%b fr=%b r2=%0d expected 0 0 0 1 1 0 0",
               name, r_o, g_o, b_o, hs_o, vs_o, frame_o, r2_o);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset("async_reset");
    model_reset();
    hs_i = 1'b1;
    vs_i = 1'b1;
    @(posedge clk);
    #1 chk_reset("reset_held");
    reset = 1'b0;
  endtask

  task automatic cyc(input logic hs, input logic vs);
    exp_t e;
    int b1, b2;
    bit hse, vse;
    @(negedge clk);
    check("frame_o", int'(frame_o), m_frame);
    check("frame2_o", int'(frame2_o), m_frame);
    if (frame_o !== last_frame) flips++;
    last_frame = frame_o;
    if (hs_o === 1'b0) begin
      hs_run++;
    end else begin
      if (hs_run > 0) hs_run_last = hs_run;
      hs_run = 0;
    end
    if (q.size() == 2) begin
      e = q.pop_front();
      ntest++;
      if (r_o !== e.r || g_o !== e.g || b_o !== e.b ||
          hs_o !== e.hs || vs_o !== e.vs || hs2_o !== e.hs ||
          vs2_o !== e.vs || r2_o !== e.r2 || g2_o !== e.r2 ||
          b2_o !== e.r2) begin
        nfail++;
        $display("FAIL pixel t=%0t got r=%0d g=%0d b=%0d hs=%b vs=%b r2=%0d expected r=%0d g=%0d b=%0d hs=%b vs=%b r2=%0d",
                 $time, r_o, g_o, b_o, hs_o, vs_o, r2_o,
                 e.r, e.g, e.b, e.hs, e.vs, e.r2);
      end
    end
    r_i = r_val;
    g_i = 6'd63 - r_val;
    b_i = r_val;
    r2_i = r2_val;
    hs_i = hs;
    vs_i = vs;
    dither_en = en_val;
    b1 = (m_en != 0) ? (bay[2 * m_y + (m_x ^ m_frame)] * 2) / 4 : 0;
    b2 = (m_en != 0) ? bay[2 * m_y + m_x] : 0;
    e.r  = 5'(sat31((int'(r_val) + b1) / 2));
    e.g  = 5'(sat31((63 - int'(r_val) + b1) / 2));
    e.b  = e.r;
    e.r2 = 5'(sat31((int'(r2_val) + b2) / 4));
    if (use_tab) begin
      e.r  = tab_r;
      e.b  = tab_r;
      e.r2 = tab_r2;
    end
    e.hs = hs;
    e.vs = vs;
    q.push_back(e);
    hse = (hs == 1'b0) && (m_hsp == 1'b1);
    vse = (vs == 1'b0) && (m_vsp == 1'b1);
    m_x = hse ? 0 : 1 - m_x;
    if (vse) m_y = 0;
    else if (hse) m_y = 1 - m_y;
    if (vse) begin
      m_frame = 1 - m_frame;
      m_en = int'(en_val);
    end
    m_hsp = hs;
    m_vsp = vs;
  endtask

  task automatic line(input int pw, input int vis, input logic vsl);
    for (int i = 0; i < pw; i++) cyc(1'b0, vsl);
    for (int i = 0; i < vis; i++) cyc(1'b1, vsl);
  endtask

  initial begin
    tab[0] = '{6'd0,  7'd0,   5'd0,  5'd0};
    tab[1] = '{6'd1,  7'd1,   5'd0,  5'd0};
    tab[2] = '{6'd2,  7'd3,   5'd1,  5'd0};
    tab[3] = '{6'd5,  7'd5,   5'd2,  5'd1};
    tab[4] = '{6'd33, 7'd64,  5'd16, 5'd16};
    tab[5] = '{6'd40, 7'd100, 5'd20, 5'd25};
    tab[6] = '{6'd62, 7'd126, 5'd31, 5'd31};
    tab[7] = '{6'd63, 7'd127, 5'd31, 5'd31};

    reset = 1'b1;
    dither_en = 1'b0;
    r_i = '0; g_i = '0; b_i = '0; r2_i = '0;
    hs_i = 1'b1; vs_i = 1'b1;
    en_val = 1'b0; use_tab = 1'b0;
    r_val = '0; r2_val = '0;
    hs_run_last = 0; flips = 0;
    model_reset();
    #3 chk_reset("power_on");
    @(posedge clk);
    #1 reset = 1'b0;

    use_tab = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r_val = tab[i].r;
      r2_val = tab[i].r2;
      tab_r = tab[i].er;
      tab_r2 = tab[i].er2;
      cyc(1'b1, 1'b1);
    end
    use_tab = 1'b0;

    r_val = 6'd63;
    r2_val = 7'd127;
    repeat (2) cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1);
    do_reset();
    repeat (6) cyc(1'b1, 1'b1);

    r_val = 6'd5;
    r2_val = 7'd1;
    en_val = 1'b1;
    line(96, 40, 1'b1);
    check("hs_pulse_width", hs_run_last, 96);

    flips = 0;
    line(96, 40, 1'b0);
    line(96, 40, 1'b1);
    check("frame_flip_once", flips, 1);
    line(96, 40, 1'b1);

    r_val = 6'd63;
    r2_val = 7'd127;
    line(96, 20, 1'b1);
    line(96, 20, 1'b1);

    r_val = 6'd5;
    r2_val = 7'd1;
    line(96, 40, 1'b0);
    line(96, 40, 1'b1);
    line(96, 40, 1'b1);

    en_val = 1'b0;
    line(96, 20, 1'b1);
    line(96, 20, 1'b0);
    line(96, 20, 1'b1);
    repeat (2) cyc(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
